// File: rtl/fpalu_issue_ctrl_pkg.sv
// Shared FP opcodes, default FP ALU latencies and issue-controller types.
// The latency defaults are also meant for the pipeline hazard logic.
package fpalu_issue_ctrl_pkg;

    localparam logic [4:0] FOPADD    = 5'd0;
    localparam logic [4:0] FOPSUB    = 5'd1;
    localparam logic [4:0] FOPMUL    = 5'd2;
    localparam logic [4:0] FOPDIV    = 5'd3;
    localparam logic [4:0] FOPSQRT   = 5'd4;
    localparam logic [4:0] FOPABS    = 5'd5;
    localparam logic [4:0] FOPNEG    = 5'd6;
    localparam logic [4:0] FOPSGNJ   = 5'd7;
    localparam logic [4:0] FOPSGNJN  = 5'd8;
    localparam logic [4:0] FOPSGNJX  = 5'd9;
    localparam logic [4:0] FOPCVTSW  = 5'd10;
    localparam logic [4:0] FOPCVTWS  = 5'd11;
    localparam logic [4:0] FOPCVTSWU = 5'd12;
    localparam logic [4:0] FOPCVTWUS = 5'd13;
    localparam logic [4:0] FOPMAX    = 5'd14;
    localparam logic [4:0] FOPMIN    = 5'd15;
    localparam logic [4:0] FOPCEQ    = 5'd16;
    localparam logic [4:0] FOPCLT    = 5'd17;
    localparam logic [4:0] FOPCLE    = 5'd18;

    localparam int unsigned DEF_LAT_ADDSUB = 7;
    localparam int unsigned DEF_LAT_MUL    = 5;
    localparam int unsigned DEF_LAT_DIV    = 6;
    localparam int unsigned DEF_LAT_SQRT   = 16;
    localparam int unsigned DEF_LAT_CVT    = 6;
    localparam int unsigned DEF_LAT_CMP    = 1;
    localparam int unsigned DEF_LAT_MISC   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_t;

    function automatic int unsigned lat_umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Ops whose only meaningful output is the compare bit; their result word is zeroed.
    function automatic logic is_cmp_op(input logic [4:0] op);
        return (op == FOPCEQ) || (op == FOPCLT) || (op == FOPCLE);
    endfunction

endpackage

// File: rtl/fpalu_issue_ctrl_if.sv
// Request / FP ALU / response bundle of the FP ALU issue controller.
interface fpalu_issue_ctrl_if;

    logic        ireq_valid;
    logic        oreq_ready;
    logic [4:0]  ireq_op;
    logic [31:0] ireq_a;
    logic [31:0] ireq_b;
    logic        ifflush;
    logic [4:0]  ofp_control;
    logic [31:0] ofp_dataa;
    logic [31:0] ofp_datab;
    logic [31:0] ifp_result;
    logic [3:0]  ifp_flags;
    logic        ifp_comp;
    logic        orsp_valid;
    logic        irsp_ready;
    logic [31:0] orsp_result;
    logic [3:0]  orsp_flags;
    logic        orsp_comp;
    logic        obusy;

    modport slave (
        input  ireq_valid, ireq_op, ireq_a, ireq_b, ifflush,
        input  ifp_result, ifp_flags, ifp_comp, irsp_ready,
        output oreq_ready, ofp_control, ofp_dataa, ofp_datab,
        output orsp_valid, orsp_result, orsp_flags, orsp_comp, obusy
    );

    modport master (
        output ireq_valid, ireq_op, ireq_a, ireq_b, ifflush,
        output ifp_result, ifp_flags, ifp_comp, irsp_ready,
        input  oreq_ready, ofp_control, ofp_dataa, ofp_datab,
        input  orsp_valid, orsp_result, orsp_flags, orsp_comp, obusy
    );

endinterface

// File: rtl/fpalu_lat_lut.sv
// Combinational FP opcode -> ALU latency lookup, shared with the hazard unit.
module fpalu_lat_lut
    import fpalu_issue_ctrl_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = DEF_LAT_ADDSUB,
    parameter int unsigned LAT_MUL    = DEF_LAT_MUL,
    parameter int unsigned LAT_DIV    = DEF_LAT_DIV,
    parameter int unsigned LAT_SQRT   = DEF_LAT_SQRT,
    parameter int unsigned LAT_CVT    = DEF_LAT_CVT,
    parameter int unsigned LAT_CMP    = DEF_LAT_CMP,
    parameter int unsigned LAT_MISC   = DEF_LAT_MISC,
    parameter int unsigned W          = 5
)(
    input  logic [4:0]   op,
    output logic [W-1:0] lat
);

    always_comb begin
        lat = W'(LAT_MISC);
        case (op)
            FOPADD, FOPSUB:                               lat = W'(LAT_ADDSUB);
            FOPMUL:                                       lat = W'(LAT_MUL);
            FOPDIV:                                       lat = W'(LAT_DIV);
            FOPSQRT:                                      lat = W'(LAT_SQRT);
            FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS:     lat = W'(LAT_CVT);
            FOPCEQ, FOPCLT, FOPCLE, FOPMAX, FOPMIN:       lat = W'(LAT_CMP);
            default:                                      lat = W'(LAT_MISC);
        endcase
    end

endmodule

// File: rtl/fpalu_issue_ctrl.sv
// FP ALU issue controller: accepts one op, holds ALU inputs for the op's fixed
// latency, then presents the captured result until the consumer takes it.
module fpalu_issue_ctrl
    import fpalu_issue_ctrl_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = DEF_LAT_ADDSUB,
    parameter int unsigned LAT_MUL    = DEF_LAT_MUL,
    parameter int unsigned LAT_DIV    = DEF_LAT_DIV,
    parameter int unsigned LAT_SQRT   = DEF_LAT_SQRT,
    parameter int unsigned LAT_CVT    = DEF_LAT_CVT,
    parameter int unsigned LAT_CMP    = DEF_LAT_CMP,
    parameter int unsigned LAT_MISC   = DEF_LAT_MISC
)(
    input  logic              iclock,
    input  logic              ireset,
    fpalu_issue_ctrl_if.slave bus
);

    localparam int unsigned LAT_MAX =
        lat_umax(lat_umax(lat_umax(LAT_ADDSUB, LAT_MUL), lat_umax(LAT_DIV, LAT_SQRT)),
                 lat_umax(lat_umax(LAT_CVT, LAT_CMP), LAT_MISC));
    localparam int unsigned CNT_W = $clog2(LAT_MAX) + 1;

    issue_state_t     state;
    issue_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_q;
    logic [CNT_W-1:0] lut_lat;
    logic [4:0]       fp_control;
    logic [31:0]      fp_dataa;
    logic [31:0]      fp_datab;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_comp;
    logic             accept;
    logic             last;
    logic             capture;

    fpalu_lat_lut #(
        .LAT_ADDSUB (LAT_ADDSUB),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_SQRT   (LAT_SQRT),
        .LAT_CVT    (LAT_CVT),
        .LAT_CMP    (LAT_CMP),
        .LAT_MISC   (LAT_MISC),
        .W          (CNT_W)
    ) u_lat_lut (
        .op  (bus.ireq_op),
        .lat (lut_lat)
    );

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush only has a target in EXEC/RESP; in IDLE a concurrent request still wins.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.ireq_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                last = (cnt == lat_q - CNT_W'(1));
                if (bus.ifflush) begin
                    state_nxt = ST_IDLE;
                end else if (last) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.ifflush || bus.irsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            cnt        <= '0;
            lat_q      <= '0;
            fp_control <= '0;
            fp_dataa   <= '0;
            fp_datab   <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_comp   <= 1'b0;
        end else begin
            if (accept) begin
                fp_control <= bus.ireq_op;
                fp_dataa   <= bus.ireq_a;
                fp_datab   <= bus.ireq_b;
                cnt        <= '0;
                lat_q      <= lut_lat;
            end else if (state == ST_EXEC && !last) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                rsp_result <= is_cmp_op(fp_control) ? '0 : bus.ifp_result;
                rsp_flags  <= bus.ifp_flags;
                rsp_comp   <= bus.ifp_comp;
            end
        end
    end

    assign bus.oreq_ready  = (state == ST_IDLE);
    assign bus.obusy       = (state != ST_IDLE);
    assign bus.orsp_valid  = (state == ST_RESP);
    assign bus.ofp_control = fp_control;
    assign bus.ofp_dataa   = fp_dataa;
    assign bus.ofp_datab   = fp_datab;
    assign bus.orsp_result = rsp_result;
    assign bus.orsp_flags  = rsp_flags;
    assign bus.orsp_comp   = rsp_comp;

endmodule

// File: tb/tb_fpalu_issue_ctrl.sv
// Scoreboard bench for fpalu_issue_ctrl with a timed FP ALU stub.
module tb_fpalu_issue_ctrl;
    import fpalu_issue_ctrl_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic        cmp;
        int          vcyc;
    } exp_t;

    logic iclock = 1'b0;
    logic ireset = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 1'b0;

    bit          stub_on   = 1'b0;
    int          stub_done = 0;
    logic [31:0] stub_res  = '0;
    logic [3:0]  stub_flg  = '0;
    logic        stub_cmp  = 1'b0;

    fpalu_issue_ctrl_if bus();

    fpalu_issue_ctrl dut (
        .iclock (iclock),
        .ireset (ireset),
        .bus    (bus)
    );

    always #5 iclock = ~iclock;
    always @(posedge iclock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ALU stub: correct values only in the op's final EXEC cycle, inverted otherwise.
    always @(negedge iclock) begin
        if (!stub_on) begin
            bus.ifp_result = '0;
            bus.ifp_flags  = '0;
            bus.ifp_comp   = 1'b0;
        end else if (cyc == stub_done) begin
            bus.ifp_result = stub_res;
            bus.ifp_flags  = stub_flg;
            bus.ifp_comp   = stub_cmp;
        end else begin
            bus.ifp_result = ~stub_res;
            bus.ifp_flags  = ~stub_flg;
            bus.ifp_comp   = ~stub_cmp;
        end
    end

    always @(negedge iclock) begin
        if (!ireset && bus.orsp_valid) begin
            if (!have_cur) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.orsp_valid), 32'd0);
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                    chk("rsp_cycle", 32'(cyc), 32'(cur.vcyc));
                    chk("rsp_result", bus.orsp_result, cur.res);
                    chk("rsp_flags", 32'(bus.orsp_flags), 32'(cur.flg));
                    chk("rsp_comp", 32'(bus.orsp_comp), 32'(cur.cmp));
                end
            end else begin
                chk("rsp_hold_result", bus.orsp_result, cur.res);
                chk("rsp_hold_flags", 32'(bus.orsp_flags), 32'(cur.flg));
            end
            if (bus.irsp_ready) have_cur = 1'b0;
        end
    end

    // rsp_lat: cycles from the accept cycle to the first orsp_valid cycle (latency+1).
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int rsp_lat, input logic [31:0] alu_res, input logic [3:0] alu_flg,
                         input logic alu_cmp, input logic [31:0] exp_res, input logic [3:0] exp_flg,
                         input logic exp_cmp, input bit expect_rsp, input bit with_flush);
        exp_t e;
        int   acc;
        @(negedge iclock);
        bus.ireq_valid = 1'b1;
        bus.ireq_op    = op;
        bus.ireq_a     = a;
        bus.ireq_b     = b;
        bus.ifflush    = with_flush;
        chk("req_ready", 32'(bus.oreq_ready), 32'd1);
        @(posedge iclock);
        #1;
        acc            = cyc;
        bus.ireq_valid = 1'b0;
        bus.ifflush    = 1'b0;
        stub_res       = alu_res;
        stub_flg       = alu_flg;
        stub_cmp       = alu_cmp;
        stub_done      = acc + rsp_lat - 2;
        stub_on        = 1'b1;
        chk("fp_control", 32'(bus.ofp_control), 32'(op));
        chk("fp_dataa", bus.ofp_dataa, a);
        chk("fp_datab", bus.ofp_datab, b);
        chk("busy_after_accept", 32'({bus.obusy, bus.oreq_ready}), 32'd2);
        if (expect_rsp) begin
            e.res  = exp_res;
            e.flg  = exp_flg;
            e.cmp  = exp_cmp;
            e.vcyc = acc + rsp_lat - 1;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || have_cur) && n < 40) begin
            @(negedge iclock);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge iclock);
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_ready"}, 32'(bus.oreq_ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus.obusy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.orsp_valid), 32'd0);
        chk({tag, "_fp_control"}, 32'(bus.ofp_control), 32'd0);
        chk({tag, "_fp_data"}, bus.ofp_dataa | bus.ofp_datab, 32'd0);
        chk({tag, "_rsp_data"}, bus.orsp_result | 32'(bus.orsp_flags) | 32'(bus.orsp_comp), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.ireq_valid = 1'b0;
        bus.ireq_op    = '0;
        bus.ireq_a     = '0;
        bus.ireq_b     = '0;
        bus.ifflush    = 1'b0;
        bus.irsp_ready = 1'b1;
        #1;
        chk_outputs_reset("reset");
        repeat (3) @(posedge iclock);
        @(negedge iclock);
        ireset = 1'b0;

        issue(FOPADD, 32'h40400000, 32'h3FC00000, 8, 32'h40900000, 4'b0000, 1'b0,
              32'h40900000, 4'b0000, 1'b0, 1'b1, 1'b0);
        drain();
        issue(FOPCLT, 32'h3F800000, 32'h40000000, 2, 32'h12345678, 4'b0000, 1'b1,
              32'h00000000, 4'b0000, 1'b1, 1'b1, 1'b0);
        drain();
        issue(FOPDIV, 32'h3F800000, 32'h00000000, 7, 32'h7F800000, 4'b0010, 1'b0,
              32'h7F800000, 4'b0010, 1'b0, 1'b1, 1'b0);
        drain();
        issue(FOPCVTSW, 32'h00000003, 32'h00000000, 7, 32'h40400000, 4'b0000, 1'b0,
              32'h40400000, 4'b0000, 1'b0, 1'b1, 1'b0);
        drain();
        issue(5'd31, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 32'h00000000, 4'b0000, 1'b0,
              32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b0);
        drain();
        // flush coincident with a request in IDLE: request must still be taken
        issue(FOPNEG, 32'h3F800000, 32'h00000000, 2, 32'hBF800000, 4'b0000, 1'b0,
              32'hBF800000, 4'b0000, 1'b0, 1'b1, 1'b1);
        drain();

        // SQRT with a stalled consumer
        bus.irsp_ready = 1'b0;
        issue(FOPSQRT, 32'h41800000, 32'h00000000, 17, 32'h40800000, 4'b0000, 1'b0,
              32'h40800000, 4'b0000, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!bus.orsp_valid && n < 30) begin
            @(negedge iclock);
            n++;
        end
        chk("sqrt_valid_seen", 32'(bus.orsp_valid), 32'd1);
        repeat (5) @(negedge iclock);
        chk("sqrt_still_valid", 32'(bus.orsp_valid), 32'd1);
        bus.irsp_ready = 1'b1;
        chk("sqrt_ready_while_resp", 32'(bus.oreq_ready), 32'd0);
        @(negedge iclock);
        chk("sqrt_ready_after_ack", 32'(bus.oreq_ready), 32'd1);
        chk("sqrt_valid_after_ack", 32'(bus.orsp_valid), 32'd0);
        drain();

        // flush in the third EXEC cycle of a MUL, then issue back-to-back
        issue(FOPMUL, 32'h40000000, 32'h40400000, 6, 32'h40C00000, 4'b0000, 1'b0,
              32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        @(negedge iclock);
        @(negedge iclock);
        @(negedge iclock);
        bus.ifflush = 1'b1;
        @(posedge iclock);
        #1;
        bus.ifflush = 1'b0;
        chk("flush_busy", 32'(bus.obusy), 32'd0);
        chk("flush_rsp_valid", 32'(bus.orsp_valid), 32'd0);
        issue(FOPSUB, 32'h40400000, 32'h3FC00000, 8, 32'h3FC00000, 4'b0000, 1'b0,
              32'h3FC00000, 4'b0000, 1'b0, 1'b1, 1'b0);
        drain();

        // async reset between edges in the middle of a SQRT
        issue(FOPSQRT, 32'h41800000, 32'h00000000, 17, 32'h40800000, 4'b0000, 1'b0,
              32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge iclock);
        #2;
        ireset = 1'b1;
        #1;
        chk_outputs_reset("midop_reset");
        @(negedge iclock);
        ireset  = 1'b0;
        stub_on = 1'b0;
        repeat (25) @(negedge iclock);
        chk("post_reset_busy", 32'(bus.obusy), 32'd0);
        chk("post_reset_queue", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
